// File: rtl/mult_ci_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_ci_pkg : shared types for the multiply custom instruction     |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package mult_ci_pkg;

  localparam int MUL_LATENCY_DEF = 3;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    MULLO = 2'd0,
    MULHI = 2'd1,
    MAC   = 2'd2,
    ACCRD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mult_ci_pkg
`default_nettype wire

// File: rtl/mult_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_pipe : signed 32x32->64 multiplier, MUL_LATENCY register stages|
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module mult_pipe
  import mult_ci_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  logic [63:0] prod_d;
  logic [63:0] stage_q [MUL_LATENCY];

  // Sign-extending both operands makes the low 64 bits the signed product.
  assign prod_d = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) stage_q[i] <= '0;
    end else if (clk_en) begin
      stage_q[0] <= prod_d;
      for (int i = 1; i < MUL_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign p = stage_q[MUL_LATENCY-1];

endmodule : mult_pipe
`default_nettype wire

// File: rtl/mult_ci_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_ci_ctrl : sequencing, accumulator and result select for the   |
// |                MULLO/MULHI/MAC/ACCRD custom instruction            |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module mult_ci_ctrl
  import mult_ci_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [63:0]        acc_q, acc_d;
  logic [31:0]        result_q, result_d;
  logic               accept;
  logic               finish_mul;
  logic [31:0]        pipe_a, pipe_b;
  logic [63:0]        prod;

  assign accept     = (state_q == IDLE) && start;
  assign finish_mul = (state_q == BUSY) && (cnt_q == CNT_W'(1));

  // Feed the live operands on the accept edge, then the latched copies, so
  // operand changes while BUSY never reach the product.
  assign pipe_a = accept ? dataa : a_q;
  assign pipe_b = accept ? datab : b_q;

  mult_pipe #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mult_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .a       (pipe_a),
    .b       (pipe_b),
    .p       (prod)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_e'(n) == ACCRD) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MUL_LATENCY);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= MULLO;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (clk_en) begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (accept) begin
      op_d = op_e'(n);
      a_d  = dataa;
      b_d  = datab;
      if (op_e'(n) == ACCRD) begin
        result_d = acc_q[31:0];
        acc_d    = '0;
      end
    end
    if (finish_mul) begin
      case (op_q)
        MULLO: result_d = prod[31:0];
        MULHI: result_d = prod[63:32];
        MAC: begin
          acc_d    = acc_q + prod;
          result_d = acc_d[31:0];
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule : mult_ci_ctrl
`default_nettype wire

// File: tb/tb_mult_ci_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mult_ci_ctrl : directed self-checking bench for mult_ci_ctrl    |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module tb_mult_ci_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fails  = 0;

  mult_ci_ctrl #(
    .MUL_LATENCY (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .n       (n),
    .dataa   (dataa),
    .datab   (datab),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction and measure latency in edges, counting the start edge as 1.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    start = 1'b1;
    n     = op;
    dataa = a;
    datab = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    @(posedge clk); #1;
    check({tag, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    reset_n = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    n       = 2'd0;
    dataa   = '0;
    datab   = '0;
    #23;
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("mullo_1x2",   2'd0, 32'd1, 32'd2, 32'd2, 4);
    run_op("mullo_2x23",  2'd0, 32'd2, 32'd23, 32'd46, 4);
    run_op("mullo_m6sq",  2'd0, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'h00000024, 4);
    run_op("mulhi_m6sq",  2'd1, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'h00000000, 4);
    run_op("mulhi_maxsq", 2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 4);
    run_op("mullo_maxsq", 2'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 4);
    run_op("mulhi_m6x7",  2'd1, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF, 4);
    run_op("mullo_m6x7",  2'd0, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFD6, 4);

    run_op("accrd_clr",   2'd3, 32'd0, 32'd0, 32'd0, 1);
    run_op("mac_3x4",     2'd2, 32'd3, 32'd4, 32'd12, 4);
    run_op("mac_5x6",     2'd2, 32'd5, 32'd6, 32'd42, 4);
    run_op("accrd_42",    2'd3, 32'd0, 32'd0, 32'd42, 1);
    run_op("accrd_0",     2'd3, 32'd0, 32'd0, 32'd0, 1);

    // Freeze two edges mid-BUSY while a conflicting start is held high.
    start = 1'b1; n = 2'd0; dataa = 32'd6; datab = 32'd7;
    @(posedge clk); #1;
    dataa  = 32'd100;
    datab  = 32'd100;
    clk_en = 1'b0;
    lat    = 1;
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      lat++;
      if (done) pulses++;
    end
    check("freeze_result_held", 64'(result), 64'd0);
    clk_en = 1'b1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done) pulses++;
    check("freeze_lat", 64'(lat), 64'd6);
    check("freeze_res", 64'(result), 64'd42);
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("freeze_pulses", 64'(pulses), 64'd1);
    check("freeze_res_hold", 64'(result), 64'd42);

    // Reset in the middle of a MAC after ACC has been made non-zero.
    run_op("mac_5x5", 2'd2, 32'd5, 32'd5, 32'd25, 4);
    start = 1'b1; n = 2'd2; dataa = 32'd7; datab = 32'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #2;
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    pulses  = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);
    run_op("midrst_accrd", 2'd3, 32'd0, 32'd0, 32'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_mult_ci_ctrl
`default_nettype wire

// File: doc/mult_ci_ctrl.md
MULT_CI_CTRL -- requirements
Module: mult_ci_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 3: pipeline depth of the multiplier in clock-enabled cycles; legal range 1..8.
REQ-002 SHALL have port clk  input  1: sole clock, rising-edge.
REQ-003 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port clk_en  input  1: global advance enable; 0 freezes all state.
REQ-005 SHALL have port start  input  1: instruction issue strobe.
REQ-006 SHALL have port n  input  2: opcode (0 MULLO, 1 MULHI, 2 MAC, 3 ACCRD).
REQ-007 SHALL have ports dataa and datab  input  32 each: signed two's-complement operands.
REQ-008 SHALL have port done  output  1: result-valid pulse.
REQ-009 SHALL have port result  output  32: instruction result.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE; transitions occur only on edges where clk_en=1.
REQ-011 SHALL accept start only in IDLE with clk_en=1; that edge latches dataa, datab and n; start in BUSY or DONE is ignored.
REQ-012 SHALL, for n=0..2, go IDLE->BUSY, hold BUSY for MUL_LATENCY enabled cycles (down-counter), then ->DONE.
REQ-013 SHALL, for n=3, go IDLE->DONE directly without using the multiplier.
REQ-014 SHALL assert done only in DONE, for exactly one enabled cycle, then return to IDLE; the earliest next start is accepted in the following cycle.
REQ-015 SHALL form the full 64-bit signed product P = dataa*datab.
REQ-016 SHALL produce result = P[31:0] for n=0 and P[63:32] for n=1.
REQ-017 SHALL, for n=2, update a 64-bit accumulator ACC <= ACC+P (wrapping modulo 2^64) on the BUSY->DONE edge and set result = new ACC[31:0].
REQ-018 SHALL, for n=3, set result = ACC[31:0] and clear ACC to 0 on the same edge.
REQ-019 SHALL register result, update it only on entry to DONE, and hold it otherwise.
REQ-020 SHALL, when clk_en=0, hold FSM state, counter, pipeline, ACC, done and result; latency therefore stretches by the number of disabled cycles.
REQ-021 SHALL make total latency, from start edge to done high, MUL_LATENCY+1 enabled cycles for n=0..2 and 1 enabled cycle for n=3.

Reset
REQ-022 SHALL, on reset_n=0, asynchronously force state=IDLE, done=0, result=0, ACC=0, counter=0 and clear all pipeline registers.
REQ-023 SHALL, on reset mid-operation, discard the in-flight instruction, produce no done pulse, and leave ACC unchanged from its reset value.
REQ-024 SHALL release from reset synchronously to clk, with the first start accepted on the first enabled edge after reset_n rises.

Structure
REQ-025 SHALL place the opcode enum (MULLO, MULHI, MAC, ACCRD), the FSM state enum and the MUL_LATENCY default in a shared package, mult_ci_pkg.
REQ-026 SHALL instantiate one sub-module, mult_pipe: a signed 32x32->64 multiplier with MUL_LATENCY register stages, with clk, reset_n and clk_en ports.
REQ-027 SHALL place all sequencing, ACC handling and result selection in mult_ci_ctrl; mult_pipe SHALL contain no control logic.

Verification
REQ-028 SHALL cover: dataa=1, datab=2, n=0 -> done after 4 cycles (MUL_LATENCY=3), result=2; then 2*23, n=0 -> result=46.
REQ-029 SHALL cover: dataa=datab=0xFFFFFFFA, n=0 -> result=0x00000024; same operands with n=1 -> result=0x00000000.
REQ-030 SHALL cover: 0x7FFFFFFF*0x7FFFFFFF with n=1 -> result=0x3FFFFFFF; with n=0 -> result=0x00000001.
REQ-031 SHALL cover: n=3 (clear), then MAC(3,4) -> 12, MAC(5,6) -> 42, n=3 -> 42, n=3 again -> 0; each n=3 done arrives 1 cycle after start.
REQ-032 SHALL cover: clk_en=0 for 2 cycles during BUSY -> done delayed exactly 2 cycles with result unchanged; start asserted while BUSY -> ignored, exactly one done pulse.
REQ-033 SHALL cover: reset_n pulsed low mid-MAC -> done stays 0, result=0, and a following n=3 returns 0.
